sp_ram_port_ctrl: RTL

- Front-end controller that sits directly upstream of the single-port block RAM model and drives its A/DI/BW/CE/RDWEN pins.
- Accepts independent valid/ready write and read request channels and arbitrates them round-robin onto the single RAM port.
- Captures read data one cycle after issue into a 2-entry response buffer with valid/ready backpressure.
- Sustains one RAM access per cycle with no response loss.

---
 rtl/sp_ram_port_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sp_ram_port_ctrl.sv
// Purpose: round-robin write/read front end for a single-port RAM, with a 2-entry read response buffer.
// Latency: RAM pins are driven in the grant cycle; read data reaches RSP_VALID one edge after the accept edge.
// Backpressure: reads are credit-gated by buffer room; writes proceed whenever no read holds the port.

// Two-entry response FIFO with 1-bit wrapping pointers and an explicit occupancy count.
module sp_ram_rsp_fifo #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   cnt
);

  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];

  // Pointer/count update and tail write; a push with a pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
    end
  end

  // Control state is cleared by reset so buffered responses are discarded.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only visible once the count covers it.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;

endmodule

module sp_ram_port_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic [DATA_WIDTH-1:0] WR_BW,
  input  logic                  RD_VALID,
  output logic                  RD_READY,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic [ADDR_WIDTH-1:0] RAM_A,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  output logic [DATA_WIDTH-1:0] RAM_BW,
  output logic                  RAM_CE,
  output logic                  RAM_RDWEN,
  input  logic [DATA_WIDTH-1:0] RAM_DO
);

  typedef enum logic {
    PRIO_RD = 1'b0,
    PRIO_WR = 1'b1
  } prio_e;

  prio_e                 prio_q, prio_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            rsp_cnt;
  logic [DATA_WIDTH-1:0] rsp_head;
  logic                  rsp_vld;
  logic                  pop;
  logic [2:0]            credit_sum;
  logic                  credit_ok;
  logic                  rd_rdy;
  logic                  wr_rdy;
  logic                  grant_rd;
  logic                  grant_wr;
  logic                  contention;

  // Arbitration: a read needs a buffer slot counting the in-flight read, net of this cycle's pop.
  always_comb begin
    rsp_vld    = (rsp_cnt != 2'd0);
    pop        = rsp_vld & RSP_READY;
    credit_sum = {1'b0, rsp_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    credit_ok  = (credit_sum < 3'd2);
    rd_rdy     = credit_ok & (!WR_VALID | (prio_q == PRIO_RD));
    wr_rdy     = !(RD_VALID & credit_ok & (prio_q == PRIO_RD));
    grant_rd   = RD_VALID & rd_rdy;
    grant_wr   = WR_VALID & wr_rdy;
    contention = WR_VALID & RD_VALID & credit_ok;
    prio_d     = prio_q;
    if (contention) begin
      prio_d = grant_rd ? PRIO_WR : PRIO_RD;
    end
    inflight_d = grant_rd;
  end

  // Priority and in-flight read tracking; reset drops any read still in the RAM pipeline.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prio_q     <= PRIO_RD;
      inflight_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      inflight_q <= inflight_d;
    end
  end

  // RAM_DO is valid the cycle after a read grant, so it is captured whenever a read is in flight.
  sp_ram_rsp_fifo #(
    .W (DATA_WIDTH)
  ) u_rsp_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .push     (inflight_q),
    .push_dat (RAM_DO),
    .pop      (pop),
    .head_dat (rsp_head),
    .cnt      (rsp_cnt)
  );

  // RAM pins are driven combinationally in the grant cycle.
  always_comb begin
    RAM_CE    = grant_rd | grant_wr;
    RAM_RDWEN = grant_wr;
    RAM_A     = grant_wr ? WR_ADDR : RD_ADDR;
    RAM_DI    = WR_DATA;
    RAM_BW    = grant_wr ? WR_BW : '0;
  end

  assign WR_READY  = wr_rdy;
  assign RD_READY  = rd_rdy;
  assign RSP_VALID = rsp_vld;
  assign RSP_DATA  = rsp_head;

endmodule
